// File: rtl/op_scheduler_pkg.sv
// op_scheduler_pkg: opcode constants, FSM encoding and opcode helpers shared by the scheduler
package op_scheduler_pkg;
    localparam logic [1:0] OPCODE_ENCRYPT = 2'b00;
    localparam logic [1:0] OPCODE_DECRYPT = 2'b01;
    localparam logic [1:0] OPCODE_ADD     = 2'b10;
    localparam logic [1:0] OPCODE_MULT    = 2'b11;

    typedef enum logic [2:0] {IDLE, FETCH_OP1, FETCH_OP2, DRAIN, DONE} state_t;

    function automatic logic is_two_operand(input logic [1:0] opcode);
        return opcode == OPCODE_ADD || opcode == OPCODE_MULT;
    endfunction
endpackage

// File: rtl/op_scheduler_cmd_fifo.sv
// cmd_fifo: generic synchronous FIFO; a count register separates full from empty
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop)
                rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/op_scheduler.sv
// op_scheduler: queued LWE command sequencer issuing per-row operand read beats; OPENENCLAVE_PERF_CNT_EN adds perf counters
import op_scheduler_pkg::*;

module op_scheduler #(
    parameter int DIMENSION   = 10,
    parameter int ADDR_WIDTH  = 10,
    parameter int CMD_DEPTH   = 4,
    parameter int MEM_LATENCY = 1,
    localparam int DIM_WIDTH  = $clog2(DIMENSION+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
    input  logic                  dp_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  op_select,
    output logic [DIM_WIDTH-1:0]  row,
    output logic [1:0]            opcode_out,
    output logic                  busy,
    output logic                  op_done,
`ifdef OPENENCLAVE_PERF_CNT_EN
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_stall_cycles,
`endif
    output logic [1:0]            op_done_opcode
);
    localparam int FW = 2 + 2*ADDR_WIDTH;
    localparam int DW = $clog2(MEM_LATENCY+1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] op1_base, op2_base;
    logic [DW-1:0]         dcnt;
    logic [FW-1:0]         f_data;
    logic                  f_full, f_empty, pop, fetch, last;
    logic [DIM_WIDTH-1:0]  row_n;

    assign cmd_ready = !f_full;
    assign pop       = state == IDLE && !f_empty;
    assign fetch     = state == FETCH_OP1 || state == FETCH_OP2;
    assign mem_rd_en = fetch && dp_ready;
    assign busy      = state != IDLE;
    assign last      = row == DIM_WIDTH'(DIMENSION);
    assign row_n     = row + DIM_WIDTH'(1);

    cmd_fifo #(.WIDTH(FW), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata ({cmd_opcode, cmd_op1_addr, cmd_op2_addr}),
        .rdata (f_data),
        .full  (f_full),
        .empty (f_empty)
    );

    // Address register always holds the beat that will issue next, so stalls need no extra handling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            op1_base       <= '0;
            op2_base       <= '0;
            mem_rd_addr    <= '0;
            op_select      <= 1'b0;
            row            <= '0;
            opcode_out     <= '0;
            dcnt           <= '0;
            op_done        <= 1'b0;
            op_done_opcode <= '0;
        end else begin
            op_done        <= 1'b0;
            op_done_opcode <= '0;
            case (state)
                IDLE: if (pop) begin
                    state       <= FETCH_OP1;
                    opcode_out  <= f_data[FW-1 -: 2];
                    op1_base    <= f_data[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
                    op2_base    <= f_data[ADDR_WIDTH-1:0];
                    mem_rd_addr <= f_data[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
                    op_select   <= 1'b0;
                    row         <= '0;
                end
                FETCH_OP1: if (dp_ready) begin
                    if (is_two_operand(opcode_out)) begin
                        state       <= FETCH_OP2;
                        mem_rd_addr <= op2_base + ADDR_WIDTH'(row);
                        op_select   <= 1'b1;
                    end else if (last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        row         <= row_n;
                        mem_rd_addr <= op1_base + ADDR_WIDTH'(row_n);
                    end
                end
                FETCH_OP2: if (dp_ready) begin
                    if (last) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        state       <= FETCH_OP1;
                        row         <= row_n;
                        mem_rd_addr <= op1_base + ADDR_WIDTH'(row_n);
                        op_select   <= 1'b0;
                    end
                end
                DRAIN: if (dcnt == DW'(MEM_LATENCY-1)) begin
                    state          <= DONE;
                    op_done        <= 1'b1;
                    op_done_opcode <= opcode_out;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OPENENCLAVE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (fetch && !dp_ready && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: directed self-checking bench for op_scheduler (default build, DIMENSION=10, MEM_LATENCY=1)
module tb_op_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_opcode = '0;
    logic [9:0] cmd_op1_addr = '0;
    logic [9:0] cmd_op2_addr = '0;
    logic       dp_ready = 1'b1;
    logic       mem_rd_en;
    logic [9:0] mem_rd_addr;
    logic       op_select;
    logic [3:0] row;
    logic [1:0] opcode_out;
    logic       busy;
    logic       op_done;
    logic [1:0] op_done_opcode;
`ifdef OPENENCLAVE_PERF_CNT_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    op_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opcode     (cmd_opcode),
        .cmd_op1_addr   (cmd_op1_addr),
        .cmd_op2_addr   (cmd_op2_addr),
        .dp_ready       (dp_ready),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .op_select      (op_select),
        .row            (row),
        .opcode_out     (opcode_out),
        .busy           (busy),
        .op_done        (op_done),
`ifdef OPENENCLAVE_PERF_CNT_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .op_done_opcode (op_done_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [9:0] a; logic s;} beat_t;
    typedef struct {int c; logic [1:0] o;} done_t;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    beat_t beats[$];
    done_t dones[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) beats.push_back('{cyc, mem_rd_addr, op_select});
        if (op_done === 1'b1) dones.push_back('{cyc, op_done_opcode});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] opc, input logic [9:0] a1, input logic [9:0] a2, output int c);
        cmd_valid = 1'b1;
        cmd_opcode = opc;
        cmd_op1_addr = a1;
        cmd_op2_addr = a2;
        c = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int k = 0;
        while (dones.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (dones.size() < n) check("timeout", dones.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag, input int n, input int c, input logic [9:0] b1,
                               input logic [9:0] b2, input logic two, input int st_at, input int st_len);
        logic [9:0] ea;
        logic       es;
        int         r;
        check({tag, "_count"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            r  = two ? i / 2 : i;
            es = two ? (i % 2 == 1) : 1'b0;
            ea = (es ? b2 : b1) + 10'(r);
            check({tag, "_cyc"}, beats[i].c, c + 2 + i + (i >= st_at ? st_len : 0));
            check({tag, "_addr"}, beats[i].a, ea);
            check({tag, "_sel"}, beats[i].s, es);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_rd_addr, 0);
        check({tag, "_sel"}, op_select, 0);
        check({tag, "_row"}, row, 0);
        check({tag, "_opc"}, opcode_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, op_done, 0);
        check({tag, "_done_opc"}, op_done_opcode, 0);
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int c, acc, refused_at, k;
        logic [1:0] exp_opc[10];
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        beats.delete(); dones.delete();
        push(2'b00, 10'h040, 10'h000, c);
        wait_dones(1, 100);
        check_beats("enc", 11, c, 10'h040, 10'h000, 1'b0, 99, 0);
        if (dones.size() > 0) begin
            check("enc_done_cyc", dones[0].c, c + 14);
            check("enc_done_opc", dones[0].o, 2'b00);
        end

        beats.delete(); dones.delete();
        push(2'b10, 10'h040, 10'h080, c);
        wait_dones(1, 100);
        check_beats("add", 22, c, 10'h040, 10'h080, 1'b1, 99, 0);
        if (dones.size() > 0) begin
            check("add_done_cyc", dones[0].c, c + 25);
            check("add_done_opc", dones[0].o, 2'b10);
        end

        beats.delete(); dones.delete();
        push(2'b11, 10'h040, 10'h080, c);
        repeat (12) @(posedge clk);
        #1 dp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rd_en", mem_rd_en, 0);
            check("stall_addr", mem_rd_addr, 10'h085);
            check("stall_sel", op_select, 1);
            @(posedge clk);
            #1;
        end
        dp_ready = 1'b1;
        wait_dones(1, 100);
        check_beats("mult", 22, c, 10'h040, 10'h080, 1'b1, 11, 3);
        if (dones.size() > 0) begin
            check("mult_done_cyc", dones[0].c, c + 28);
            check("mult_done_opc", dones[0].o, 2'b11);
        end

        beats.delete(); dones.delete();
        acc = 0;
        refused_at = -1;
        k = 0;
        while (acc < 10 && k < 2000) begin
            exp_opc[acc] = 2'(acc);
            cmd_valid = 1'b1;
            cmd_opcode = 2'(acc);
            cmd_op1_addr = 10'(acc * 16);
            cmd_op2_addr = 10'(10'h200 + acc * 16);
            @(negedge clk);
            if (cmd_ready) acc++;
            else if (refused_at < 0) refused_at = acc;
            @(posedge clk);
            #1;
            k++;
        end
        cmd_valid = 1'b0;
        check("q_accepted", acc, 10);
        check("q_first_refusal", refused_at, 5);
        wait_dones(10, 2000);
        check("q_done_count", dones.size(), 10);
        for (int i = 0; i < 10 && i < dones.size(); i++)
            check("q_order_opc", dones[i].o, exp_opc[i]);

        beats.delete(); dones.delete();
        push(2'b01, 10'h3FC, 10'h000, c);
        wait_dones(1, 100);
        check_beats("wrap", 11, c, 10'h3FC, 10'h000, 1'b0, 99, 0);
        if (dones.size() > 0) check("wrap_done_opc", dones[0].o, 2'b01);

        beats.delete(); dones.delete();
        push(2'b10, 10'h040, 10'h080, c);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("mid_rst");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mid_rst_no_done", dones.size(), 0);

        beats.delete(); dones.delete();
        push(2'b00, 10'h100, 10'h000, c);
        wait_dones(1, 100);
        check_beats("post_rst", 11, c, 10'h100, 10'h000, 1'b0, 99, 0);
        if (dones.size() > 0) check("post_rst_done_cyc", dones[0].c, c + 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/op_scheduler.md
Name: op_scheduler

Overview:
- Command-queued sequencer in front of the LWE ciphertext datapath.
- Accepts encrypt/decrypt/add/mult commands through a valid/ready port and buffers them in a small FIFO.
- For each command, walks every ciphertext row and issues operand read beats (op1, and op2 for two-operand ops) to the ciphertext SRAM/datapath. Obeys datapath backpressure.
- Signals completion with a one-cycle op_done pulse after the memory pipeline drains.

Parameters:
- DIMENSION, 10, LWE dimension n; a ciphertext has DIMENSION+1 rows.
- ADDR_WIDTH, 10, SRAM address width.
- CMD_DEPTH, 4, command FIFO depth (power of 2, >=2).
- MEM_LATENCY, 1, SRAM read latency in cycles, drained before op_done (>=1).
- Localparam DIM_WIDTH = $clog2(DIMENSION+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_opcode  in  2  00 ENCRYPT, 01 DECRYPT, 10 ADD, 11 MULT
- cmd_op1_addr  in  ADDR_WIDTH  operand-1 base address
- cmd_op2_addr  in  ADDR_WIDTH  operand-2 base address (ignored for ENCRYPT/DECRYPT)
- dp_ready  in  1  datapath can accept a beat this cycle
- mem_rd_en  out  1  read beat issued
- mem_rd_addr  out  ADDR_WIDTH  beat address
- op_select  out  1  0 = op1 beat, 1 = op2 beat
- row  out  DIM_WIDTH  current row index
- opcode_out  out  2  opcode of active command
- busy  out  1  state != IDLE
- op_done  out  1  one-cycle completion pulse
- op_done_opcode  out  2  opcode of completed command, valid with op_done

Behaviour:
- Reset (rst_n=0 at posedge) has priority over everything.
  - FIFO emptied; state IDLE.
  - All outputs 0 except cmd_ready=1.
  - Reset mid-command aborts it: no op_done is produced.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full, combinational from FIFO count only, so a push is refused when full even if a pop happens the same cycle.
  - Pointers wrap modulo CMD_DEPTH; a count register distinguishes full from empty.
- FSM states: IDLE, FETCH_OP1, FETCH_OP2, DRAIN, DONE.
- IDLE:
  - If FIFO is non-empty: pop, latch opcode/op1/op2 base, row=0, go to FETCH_OP1.
  - A command pushed in cycle C is popped in C+1; its first beat can issue in C+2.
- FETCH_OP1:
  - mem_rd_en = dp_ready; mem_rd_addr = op1_base + row; op_select = 0.
  - On beat (dp_ready=1):
    - ADD/MULT → FETCH_OP2.
    - Otherwise, if row==DIMENSION → DRAIN; else row++.
- FETCH_OP2:
  - mem_rd_en = dp_ready; mem_rd_addr = op2_base + row; op_select = 1.
  - On beat: if row==DIMENSION → DRAIN; else row++ and → FETCH_OP1.
- Stall: dp_ready=0 holds state, row, address and op_select; mem_rd_en=0. No beat is lost or duplicated.
- DRAIN: count MEM_LATENCY cycles, then → DONE.
- DONE: op_done=1 and op_done_opcode=latched opcode for exactly one cycle, then → IDLE.
- Address arithmetic: base + row is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. No error is flagged.
- Beat count: N = DIMENSION+1 for ENCRYPT/DECRYPT; N = 2*(DIMENSION+1) for ADD/MULT.
- Latency with dp_ready held high: op_done at C+2+N+MEM_LATENCY.
- mem_rd_en, mem_rd_addr, op_select, row and opcode_out are registered state outputs; the mem_rd_en gating with dp_ready is the only combinational path.

Optional Feature:
- Macro: OPENENCLAVE_PERF_CNT_EN.
- When defined, adds 32-bit outputs:
  - perf_busy_cycles: increments while busy.
  - perf_stall_cycles: increments in FETCH_OP1/FETCH_OP2 with dp_ready=0.
  - Both saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent, with identical behaviour otherwise.

Decomposition:
- Shared package holds:
  - opcode constants OPCODE_ENCRYPT/DECRYPT/ADD/MULT (2'b00..2'b11);
  - FSM state encoding;
  - an is_two_operand(opcode) function.
- Sub-module cmd_fifo: generic synchronous FIFO parameterised on width and depth, instantiated once with width 2+2*ADDR_WIDTH.

Test Plan:
- ENCRYPT, op1=0x040, dp_ready=1, accepted in cycle C:
  - 11 beats at C+2..C+12, addresses 0x040..0x04A, op_select=0;
  - op_done with op_done_opcode=00 at C+14.
- ADD, op1=0x040, op2=0x080:
  - 22 beats alternating 0x040,0x080,0x041,0x081,…,0x04A,0x08A, with op_select toggling 0,1;
  - op_done at C+25.
- MULT with dp_ready low for 3 cycles during row 5 op2:
  - mem_rd_en=0 and address 0x085 held;
  - resumes with no duplicate or missing beats;
  - op_done is 3 cycles later than the unstalled case.
- Queue full and wrap-around: 5 back-to-back pushes while the first command runs:
  - cmd_ready drops after the queue fills (4 buffered);
  - commands complete in push order with correct opcodes;
  - FIFO pointers wrap at least twice across 10 commands.
- Address wrap: op1=0x3FC, DECRYPT, ADDR_WIDTH=10 → addresses 0x3FC..0x3FF, then 0x000..0x006.
- Reset asserted during row 3 of ADD:
  - next cycle all outputs are 0, cmd_ready=1 and busy=0;
  - op_done never pulses;
  - a new command afterwards runs normally.
